bcd_digit_serial_ctrl: RTL

//   Controller that time-shares one 1-digit BCD adder (sum, compare > 9, subtract 10, carry out) across NDIGITS.

---
 rtl/bcd_digit_serial_ctrl.sv | 164 ++++++++++++++++
 1 files changed

// File: rtl/bcd_digit_serial_ctrl.sv
// bcd_digit_serial_ctrl
//
// Adds two packed multi-digit BCD operands using one shared 1-digit BCD
// adder. Digits are processed least-significant first, one per clock, and
// a start/busy/done handshake frames each operation. Used between the
// operand registers and the HEX display decoders.
//
// Parameters
//   NDIGITS  number of BCD digits per operand (>= 1)
//
// Ports
//   Clock   in   1          rising-edge clock
//   Resetn  in   1          synchronous active-low reset
//   Start   in   1          request a new addition (sampled only in IDLE)
//   A       in   4*NDIGITS  operand A, packed BCD, digit i = A[4i+3:4i]
//   B       in   4*NDIGITS  operand B, same packing
//   Cin     in   1          carry into digit 0
//   Sum     out  4*NDIGITS  result, packed BCD
//   Cout    out  1          carry out of the most-significant digit
//   Busy    out  1          high while loading or adding
//   Done    out  1          one-cycle pulse when results are valid
//   Err     out  1          sticky flag: a digit > 9 was seen in A or B

module bcd_digit_serial_ctrl #(
    parameter int NDIGITS = 4
) (
    input  logic                   Clock,
    input  logic                   Resetn,
    input  logic                   Start,
    input  logic [4*NDIGITS-1:0]   A,
    input  logic [4*NDIGITS-1:0]   B,
    input  logic                   Cin,
    output logic [4*NDIGITS-1:0]   Sum,
    output logic                   Cout,
    output logic                   Busy,
    output logic                   Done,
    output logic                   Err
);

    localparam int              CW       = $clog2(NDIGITS + 1);
    localparam int              W        = 4 * NDIGITS;
    localparam logic [CW-1:0]   LAST_IDX = CW'(NDIGITS - 1);

    typedef enum logic [1:0] {
        S_IDLE,
        S_LOAD,
        S_ADD,
        S_DONE
    } state_t;

    state_t          state;
    state_t          state_next;

    logic [W-1:0]    a_reg;
    logic [W-1:0]    b_reg;
    logic [W-1:0]    sum_reg;
    logic            carry;
    logic            cout_reg;
    logic            err_reg;
    logic [CW-1:0]   idx;

    logic [3:0]      a_digit;
    logic [3:0]      b_digit;
    logic [4:0]      raw;
    logic [3:0]      digit;
    logic            carry_next;
    logic            digit_bad;

    // Shared single-digit BCD adder working on the digit selected by idx.
    // When the raw sum exceeds 9, (raw - 10) mod 16 equals raw[3:0] + 6
    // mod 16, which keeps the correction to a 4-bit add.
    always_comb begin
        a_digit    = a_reg[int'(idx)*4 +: 4];
        b_digit    = b_reg[int'(idx)*4 +: 4];
        raw        = {1'b0, a_digit} + {1'b0, b_digit} + {4'b0000, carry};
        digit      = raw[3:0];
        carry_next = 1'b0;
        if (raw > 5'd9) begin
            digit      = raw[3:0] + 4'd6;
            carry_next = 1'b1;
        end
        digit_bad  = (a_digit > 4'd9) || (b_digit > 4'd9);
    end

    // Next-state and handshake outputs.
    always_comb begin
        state_next = state;
        Busy       = 1'b0;
        Done       = 1'b0;
        case (state)
            S_IDLE: begin
                if (Start) begin
                    state_next = S_LOAD;
                end
            end
            S_LOAD: begin
                Busy       = 1'b1;
                state_next = S_ADD;
            end
            S_ADD: begin
                Busy = 1'b1;
                if (idx == LAST_IDX) begin
                    state_next = S_DONE;
                end
            end
            S_DONE: begin
                Done       = 1'b1;
                state_next = S_IDLE;
            end
            default: begin
                state_next = S_IDLE;
            end
        endcase
    end

    // State register plus datapath. Operands are captured on the accepted
    // Start so later input changes cannot disturb a running addition.
    always_ff @(posedge Clock) begin
        if (!Resetn) begin
            state    <= S_IDLE;
            a_reg    <= '0;
            b_reg    <= '0;
            sum_reg  <= '0;
            carry    <= 1'b0;
            cout_reg <= 1'b0;
            err_reg  <= 1'b0;
            idx      <= '0;
        end else begin
            state <= state_next;
            case (state)
                S_IDLE: begin
                    if (Start) begin
                        a_reg    <= A;
                        b_reg    <= B;
                        carry    <= Cin;
                        idx      <= '0;
                        sum_reg  <= '0;
                        cout_reg <= 1'b0;
                        err_reg  <= 1'b0;
                    end
                end
                S_ADD: begin
                    sum_reg[int'(idx)*4 +: 4] <= digit;
                    carry                     <= carry_next;
                    if (digit_bad) begin
                        err_reg <= 1'b1;
                    end
                    if (idx == LAST_IDX) begin
                        cout_reg <= carry_next;
                    end else begin
                        idx <= idx + CW'(1);
                    end
                end
                default: begin
                end
            endcase
        end
    end

    assign Sum  = sum_reg;
    assign Cout = cout_reg;
    assign Err  = err_reg;

endmodule
